mem_bridge: RTL and testbench
=============================

# mem_bridge

Word-access front end for the 8-bit `ram` block, sitting between the CPU datapath and the RAM. It accepts one 16-bit read or write request at a time and splits it into two sequential byte accesses: low byte first, then high byte. It sequences the RAM `read`/`write` strobes and waits on the RAM `ready_r`/`ready_w` acknowledges. It returns a one-cycle `done` pulse with the assembled word.

## Interface
Parameters:
- `size_addr`, 8: byte-address width; must match the RAM instance.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high; clock `clk`.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  size_addr  byte address of the low byte.
- `wdata`  in  16  write word.
- `rdata`  out  16  read word; registered.
- `busy`  out  1  high while a transaction is in flight.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  alignment error flag; valid with `done`.
- `ram_read`  out  1  to RAM `read`.
- `ram_write`  out  1  to RAM `write`.
- `ram_addr`  out  size_addr  to RAM `address`.
- `ram_din`  out  8  to RAM `data_in`.
- `ram_dout`  in  8  from RAM `data_out`.
- `ram_ready_r`  in  1  from RAM; high the cycle after a read strobe.
- `ram_ready_w`  in  1  from RAM; high the cycle after a write strobe.

## Operation
- Byte order is little-endian: the low byte is at `addr` and the high byte is at `addr+1`.
- `addr+1` is computed modulo 2^size_addr, so 0xFF wraps to 0x00.
- FSM states:
  - IDLE → ISSUE_LO on `req`.
  - ISSUE_LO → WAIT_LO, unconditionally.
  - WAIT_LO → ISSUE_HI on ready.
  - ISSUE_HI → WAIT_HI, unconditionally.
  - WAIT_HI → IDLE on ready, asserting `done`.
- "Ready" means `ram_ready_r` for reads and `ram_ready_w` for writes. The WAIT states hold indefinitely until ready arrives.
- `we`, `addr` and `wdata` are latched on acceptance. Later changes to these inputs have no effect on the transaction in flight.
- All RAM-side outputs are registered.
  - `ram_read` or `ram_write` is high for exactly one cycle per byte, never both.
  - `ram_addr` and `ram_din` are held stable from the strobe until the next strobe.
- Reads:
  - The low byte is captured into `rdata[7:0]` in WAIT_LO.
  - The high byte is captured into `rdata[15:8]` in WAIT_HI.
  - `rdata` is valid from the `done` cycle and holds until the next read completes.
- Writes:
  - The low strobe carries `wdata[7:0]`; the high strobe carries `wdata[15:8]`.
  - `rdata` is unchanged by a write.
- `req` while `busy` is ignored: it is not queued. The requester must wait for `done`.
- Reset values: `rdata`=0, `busy`=0, `done`=0, `err`=0, `ram_read`=0, `ram_write`=0, `ram_addr`=0, `ram_din`=0, FSM=IDLE.
- Reset mid-transaction aborts the transaction with no `done` pulse; the RAM clears in the same cycle.

## Timing
Edge k is the edge at which `req` is sampled in IDLE.
- Edge k: latch the request; `busy`=1; low strobe asserted after edge k.
- Edge k+1: the RAM performs the low access; strobe deasserts.
- Edge k+2: low ready seen; capture the low byte; high strobe asserted.
- Edge k+3: the RAM performs the high access; strobe deasserts.
- Edge k+4: high ready seen; capture the high byte; `done`=1 for one cycle; `busy`=0; FSM=IDLE.
- The earliest next acceptance is edge k+5. Throughput is one word per 5 cycles.
- A held `req` is therefore accepted again at edge k+5.

## Configuration
- `MEM_BRIDGE_ALIGN_CHECK_EN` defined:
  - A request with `addr[0]`=1 issues no RAM strobe.
  - At edge k the block sets `done`=1 and `err`=1 for one cycle and stays in IDLE.
  - `rdata` is unchanged.
- `MEM_BRIDGE_ALIGN_CHECK_EN` undefined:
  - Odd addresses are accepted and processed normally, including wrap-around.
  - `err` is tied to 0.

## Test plan
- Write 0xBEEF @0x10, then read @0x10 → `rdata`=0xBEEF; RAM bytes 0x10=0xEF and 0x11=0xBE.
- Read request at edge k → exactly one `ram_read` pulse after edge k and after edge k+2; `done` high only after edge k+4; `busy` high between.
- Macro undefined: write 0x1234 @0xFF → RAM byte 0xFF=0x34 and 0x00=0x12; read back gives 0x1234 with `err`=0. Macro defined: the same request gives `done`=`err`=1 at edge k and no RAM strobes.
- `req` toggled with new `addr`/`wdata` during WAIT_LO → ignored; only the original transaction completes with one `done`.
- Assert `reset` at edge k+2 of a write → all outputs 0, no `done`, FSM IDLE; a subsequent read of any address returns 0x0000.
- Hold `req` high with `we`=0 continuously → `done` pulses every 5 cycles and each `rdata` matches the memory contents.

Source files
------------

// File: rtl/mem_bridge.sv
// 16-bit word front end for the 8-bit ram: splits each request into a low then high byte access.
// Optional MEM_BRIDGE_ALIGN_CHECK_EN rejects odd addresses with a done+err pulse and no RAM access.
module mem_bridge #(
  parameter int size_addr = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [size_addr-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic [size_addr-1:0] ram_addr,
  output logic [7:0]           ram_din,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_ready_r,
  input  logic                 ram_ready_w
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_WAIT_LO,
    S_ISSUE_HI,
    S_WAIT_HI
  } state_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [size_addr-1:0] addr_hi_q, addr_hi_d;
  logic [7:0]           wdata_hi_q, wdata_hi_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ram_read_q, ram_read_d;
  logic                 ram_write_q, ram_write_d;
  logic [size_addr-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]           ram_din_q, ram_din_d;
  logic                 misaligned;
  logic                 ready;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misaligned = addr[0];
  assign err        = err_q;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  // The acknowledge that matters depends on the latched direction, not the live input.
  assign ready = we_q ? ram_ready_w : ram_ready_r;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_hi_d   = addr_hi_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && misaligned) begin
          done_d = 1'b1;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
          err_d  = 1'b1;
`endif
        end else if (req) begin
          state_d     = S_ISSUE_LO;
          we_d        = we;
          addr_hi_d   = addr + size_addr'(1);
          wdata_hi_d  = wdata[15:8];
          busy_d      = 1'b1;
          ram_read_d  = ~we;
          ram_write_d = we;
          ram_addr_d  = addr;
          if (we) ram_din_d = wdata[7:0];
        end
      end
      S_ISSUE_LO: state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (ready) begin
          if (!we_q) rdata_d[7:0] = ram_dout;
          state_d     = S_ISSUE_HI;
          ram_read_d  = ~we_q;
          ram_write_d = we_q;
          ram_addr_d  = addr_hi_q;
          if (we_q) ram_din_d = wdata_hi_q;
        end
      end
      S_ISSUE_HI: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (ready) begin
          if (!we_q) rdata_d[15:8] = ram_dout;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_hi_q   <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_hi_q   <= addr_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: byte RAM model plus a word-level reference memory, directed and random steps.
module tb_mem_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        busy, done, err;
  logic        ram_read, ram_write;
  logic [7:0]  ram_addr, ram_din, ram_dout;
  logic        ram_ready_r, ram_ready_w;

  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int rd_p = 0, wr_p = 0, dn_p = 0, both_p = 0;
  bit align_en;

  always #5 clk = ~clk;

  mem_bridge #(.size_addr(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ready_r(ram_ready_r), .ram_ready_w(ram_ready_w)
  );

  // Byte RAM: acknowledges one cycle after a strobe, clears on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      ram_ready_r <= 1'b0;
      ram_ready_w <= 1'b0;
      ram_dout    <= 8'h00;
    end else begin
      ram_ready_r <= ram_read;
      ram_ready_w <= ram_write;
      if (ram_read)  ram_dout <= ram_mem[ram_addr];
      if (ram_write) ram_mem[ram_addr] <= ram_din;
    end
  end

  always @(negedge clk) begin
    if (ram_read)  rd_p <= rd_p + 1;
    if (ram_write) wr_p <= wr_p + 1;
    if (done)      dn_p <= dn_p + 1;
    if (ram_read && ram_write) both_p <= both_p + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_word(input logic [7:0] a);
    return {ref_mem[8'(a + 8'd1)], ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [15:0] wd);
    ref_mem[a] = wd[7:0];
    ref_mem[8'(a + 8'd1)] = wd[15:8];
  endtask

  // One request; inputs are scrambled right after acceptance to prove they were latched.
  task automatic txn(input bit w, input logic [7:0] a, input logic [15:0] wd,
                     output logic [15:0] rd, output logic e, output int lat);
    we = w; addr = a; wdata = wd; req = 1'b1;
    step();
    req = 1'b0; we = ~w; addr = 8'($urandom); wdata = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    if (!done) chk("txn_timeout", {31'd0, done}, 32'd1);
    rd = rdata;
    e  = err;
    step();
  endtask

  initial begin
    logic [15:0] rd;
    logic        e;
    int          lat, r0, w0, d0, t, prev;
    logic [7:0]  a;
    logic [15:0] wd;
    bit          w;
    logic [7:0]  held_addr [3];

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    repeat (3) step();
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {ram_read, ram_write}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    reset = 1'b0;
    step();

    // Write 0xBEEF @0x10 and check byte placement.
    r0 = rd_p; w0 = wr_p;
    txn(1'b1, 8'h10, 16'hBEEF, rd, e, lat);
    ref_write(8'h10, 16'hBEEF);
    chk("wr_lat", lat, 4);
    chk("wr_mem10", ram_mem[8'h10], 8'hEF);
    chk("wr_mem11", ram_mem[8'h11], 8'hBE);
    chk("wr_strobes", {wr_p - w0, rd_p - r0}, {32'd2, 32'd0});

    // Cycle-by-cycle read @0x10.
    r0 = rd_p; w0 = wr_p;
    we = 1'b0; addr = 8'h10; req = 1'b1;
    step();
    req = 1'b0; addr = 8'h77;
    chk("t_k_busy", busy, 1);
    chk("t_k_read", ram_read, 1);
    chk("t_k_addr", ram_addr, 8'h10);
    chk("t_k_done", done, 0);
    step();
    chk("t_k1_read", ram_read, 0);
    chk("t_k1_busy", busy, 1);
    step();
    chk("t_k2_read", ram_read, 1);
    chk("t_k2_addr", ram_addr, 8'h11);
    chk("t_k2_lo", rdata[7:0], 8'hEF);
    chk("t_k2_done", done, 0);
    step();
    chk("t_k3_read", ram_read, 0);
    chk("t_k3_done", done, 0);
    step();
    chk("t_k4_done", done, 1);
    chk("t_k4_busy", busy, 0);
    chk("t_k4_rdata", rdata, 16'hBEEF);
    step();
    chk("t_k5_done", done, 0);
    chk("t_read_pulses", rd_p - r0, 2);
    chk("t_write_pulses", wr_p - w0, 0);

    // Word at the top of the address space.
    r0 = rd_p; w0 = wr_p;
    txn(1'b1, 8'hFF, 16'h1234, rd, e, lat);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    chk("ff_err", e, 1);
    chk("ff_lat", lat, 0);
    chk("ff_no_strobes", (rd_p - r0) + (wr_p - w0), 0);
    chk("ff_busy", busy, 0);
    chk("ff_rdata_kept", rdata, 16'hBEEF);
`else
    ref_write(8'hFF, 16'h1234);
    chk("ff_err", e, 0);
    chk("ff_memFF", ram_mem[8'hFF], 8'h34);
    chk("ff_mem00", ram_mem[8'h00], 8'h12);
    txn(1'b0, 8'hFF, 16'h0000, rd, e, lat);
    chk("ff_read", rd, 16'h1234);
    chk("ff_read_err", e, 0);
`endif

    // req with new fields during WAIT_LO/WAIT_HI is ignored.
    d0 = dn_p;
    we = 1'b1; addr = 8'h20; wdata = 16'h5A11; req = 1'b1;
    step();
    req = 1'b0;
    step();
    req = 1'b1; addr = 8'h40; wdata = 16'h2222;
    step();
    req = 1'b0; we = 1'b0; addr = 8'h41;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (8) step();
    ref_write(8'h20, 16'h5A11);
    chk("ign_done_count", dn_p - d0, 1);
    chk("ign_mem20", ram_mem[8'h20], 8'h11);
    chk("ign_mem21", ram_mem[8'h21], 8'h5A);
    chk("ign_mem40", ram_mem[8'h40], ref_mem[8'h40]);
    chk("ign_mem41", ram_mem[8'h41], ref_mem[8'h41]);

    // Random traffic over a small window so reads hit earlier writes.
    for (int i = 0; i < 24; i++) begin
      a  = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | 8'hF0;
      w  = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      r0 = rd_p; w0 = wr_p;
      txn(w, a, wd, rd, e, lat);
      if (align_en && a[0]) begin
        chk("rnd_err", e, 1);
        chk("rnd_no_strobes", (rd_p - r0) + (wr_p - w0), 0);
      end else begin
        chk("rnd_err", e, 0);
        chk("rnd_lat", lat, 4);
        if (w) begin
          ref_write(a, wd);
          chk("rnd_wr_word", {ram_mem[8'(a + 8'd1)], ram_mem[a]}, wd);
        end else begin
          chk("rnd_rd_word", rd, ref_word(a));
        end
      end
      chk("rnd_no_both", both_p, 0);
    end

    // Reset at edge k+2 of a write.
    d0 = dn_p;
    we = 1'b1; addr = 8'h30; wdata = 16'hABCD; req = 1'b1;
    step();
    req = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_strobes", {ram_read, ram_write}, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_din", ram_din, 0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (6) step();
    chk("mid_rst_no_done", dn_p - d0, 0);
    a = 8'($urandom) & 8'hFE;
    txn(1'b0, a, 16'h0, rd, e, lat);
    chk("post_rst_read", rd, 16'h0000);
    txn(1'b0, 8'h30, 16'h0, rd, e, lat);
    chk("post_rst_read30", rd, 16'h0000);

    // Held read request: one word per 5 cycles.
    held_addr[0] = 8'h50; held_addr[1] = 8'h52; held_addr[2] = 8'h54;
    txn(1'b1, 8'h50, 16'h1357, rd, e, lat); ref_write(8'h50, 16'h1357);
    txn(1'b1, 8'h52, 16'h2468, rd, e, lat); ref_write(8'h52, 16'h2468);
    txn(1'b1, 8'h54, 16'h9ABC, rd, e, lat); ref_write(8'h54, 16'h9ABC);
    we = 1'b0; addr = held_addr[0]; req = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      do begin
        step();
        t++;
      end while (!done && t < 20);
      chk("held_done", done, 1);
      chk("held_rdata", rdata, ref_word(held_addr[i]));
      if (i > 0) chk("held_period", cyc - prev, 5);
      prev = cyc;
      if (i < 2) addr = held_addr[i + 1];
      else req = 1'b0;
    end
    repeat (4) step();
    chk("held_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
